reservation_station: RTL and testbench
======================================

// Module: reservation_station
// PURPOSE
//  Holds decoded ALU-class instructions (ARITH, ARITHI, LUI, AUIPC, B, JAL, JALR) until both source operands are known.
//  Captures operands from the ALU and LSB result broadcasts.
//  Sends at most one ready instruction per cycle to the ALU over the RS->ALU interface; it is the sender of that interface.
//  Sits between the decoder/issue stage and the ALU; flushed on rollback.
// PARAMETERS
//  RS_SIZE      16  number of entries, power of two
//  ROB_ID_WIDTH  4  ROB tag width; ports marked ROB carry this width
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous active-high reset
//  rdy            in   1   global enable; when low all state holds
//  rollback       in   1   mispredict flush (synchronous)
//  in_valid       in   1   decoder issues one instruction this cycle
//  in_opcode      in   7   opcode
//  in_func3       in   3   func3
//  in_func1       in   1   funct7[5]
//  in_rs1_val     in   32  rs1 value; valid when in_rs1_rdy=1
//  in_rs1_rdy     in   1   rs1 value is final
//  in_rs1_tag     in   ROB producer tag of rs1 when not ready
//  in_rs2_val/rdy/tag      same set of three ports for rs2
//  in_imm         in   32  immediate
//  in_off         in   32  branch/jump offset
//  in_pc          in   32  instruction pc
//  in_rob_target  in   ROB destination ROB entry
//  alu_valid      in   1   ALU result broadcast valid
//  alu_rob        in   ROB ALU result tag
//  alu_data       in   32  ALU result data
//  lsb_valid/lsb_rob/lsb_data  in   same broadcast set from the LSB
//  rs_full        out  1   combinational: no free entry; decoder must not assert in_valid
//  out_inst_valid out  1   one-cycle issue pulse to ALU
//  out_opcode, out_func3, out_func1, out_data1, out_data2, out_imm, out_off, out_pc, out_rob_target  out  same widths as in_*
// BEHAVIOUR
//  Entry state: busy, op fields, V1/V2 (32b), Q1/Q2 (ROB), R1/R2 ready bits.
//  Reset or rollback (both sync): all busy=0, out_inst_valid=0, all other outputs 0; count=0.
//  rdy=0: no state change; outputs hold their values, including out_inst_valid.
//  Insert, when in_valid and rdy:
//   - Instruction is written into the lowest-index non-busy entry.
//   - Same-cycle bypass: if an operand has rdy=0 and its tag matches alu_rob with alu_valid (or lsb_rob with lsb_valid), it is stored ready with the broadcast data. ALU takes priority if both match.
//   - in_valid while rs_full is a protocol violation; the instruction is dropped and the bench asserts on it.
//  Wakeup, every rdy cycle:
//   - Each busy entry with Rk=0 and Qk equal to a valid broadcast tag sets Vk=data and Rk=1.
//   - ALU and LSB broadcasts are both applied in the same cycle.
//  Dispatch:
//   - Selects the lowest-index busy entry with R1&R2=1, evaluated on registered state at the clock edge.
//   - Selected entry: busy cleared; out_* registered, out_inst_valid=1 for exactly one cycle.
//   - If no entry is ready, out_inst_valid=0 and the other outputs hold their values.
//   - Latency: an operand-ready instruction inserted at edge N dispatches at edge N+1, and out_inst_valid is seen high after N+1.
//   - An entry woken at edge N is eligible at edge N+1.
//  Operands not used by the opcode (LUI, AUIPC, JAL, and rs2 of ARITHI/JALR) must be issued with rdy=1 by the decoder; the RS does not decode them.
//  Simultaneous insert and dispatch in one cycle:
//   - Legal even when exactly one entry is free.
//   - The freed entry becomes reusable next cycle, not the same cycle.
//  rs_full = (number of busy entries == RS_SIZE), computed from registered busy bits.
//  rollback takes priority over in_valid and broadcasts arriving in the same cycle.
// TESTING
//  1. Reset, then in_valid ADD with rs1=5, rs2=7, both ready, rob 3 -> next cycle out_inst_valid=1, data1=5, data2=7, rob_target=3; following cycle out_inst_valid=0.
//  2. Insert SUB with rs1 waiting on tag 2. One cycle later, alu_valid with rob 2, data 0x10 -> dispatch one cycle after the broadcast with data1=0x10.
//  3. Insert with rs2 tag 5 in the same cycle as lsb_valid, rob 5, data 0xAB -> stored ready; dispatches next cycle with data2=0xAB.
//  4. Fill 16 entries, all waiting on tag 9 -> rs_full=1. Broadcast tag 9 -> entries dispatch in index order 0..15, one per cycle; rs_full drops after the first dispatch.
//  5. Four entries pending, assert rollback -> next cycle rs_full=0 and out_inst_valid=0. A later tag broadcast produces no dispatch.
//  6. Hold rdy=0 for 3 cycles with a ready entry and a broadcast -> no dispatch and no wakeup. Raise rdy -> dispatch proceeds as if those cycles never occurred.

Source files
------------

// File: rtl/reservation_station.sv
// Reservation station for ALU-class instructions: buffers entries until both
// operands are known, snoops ALU/LSB broadcasts and issues one ready entry per cycle.
module reservation_station #(
  parameter int RS_SIZE      = 16,
  parameter int ROB_ID_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    rollback,
  input  logic                    in_valid,
  input  logic [6:0]              in_opcode,
  input  logic [2:0]              in_func3,
  input  logic                    in_func1,
  input  logic [31:0]             in_rs1_val,
  input  logic                    in_rs1_rdy,
  input  logic [ROB_ID_WIDTH-1:0] in_rs1_tag,
  input  logic [31:0]             in_rs2_val,
  input  logic                    in_rs2_rdy,
  input  logic [ROB_ID_WIDTH-1:0] in_rs2_tag,
  input  logic [31:0]             in_imm,
  input  logic [31:0]             in_off,
  input  logic [31:0]             in_pc,
  input  logic [ROB_ID_WIDTH-1:0] in_rob_target,
  input  logic                    alu_valid,
  input  logic [ROB_ID_WIDTH-1:0] alu_rob,
  input  logic [31:0]             alu_data,
  input  logic                    lsb_valid,
  input  logic [ROB_ID_WIDTH-1:0] lsb_rob,
  input  logic [31:0]             lsb_data,
  output logic                    rs_full,
  output logic                    out_inst_valid,
  output logic [6:0]              out_opcode,
  output logic [2:0]              out_func3,
  output logic                    out_func1,
  output logic [31:0]             out_data1,
  output logic [31:0]             out_data2,
  output logic [31:0]             out_imm,
  output logic [31:0]             out_off,
  output logic [31:0]             out_pc,
  output logic [ROB_ID_WIDTH-1:0] out_rob_target
);

  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0]      busy;
  logic [RS_SIZE-1:0]      r1;
  logic [RS_SIZE-1:0]      r2;
  logic [6:0]              opcode [RS_SIZE];
  logic [2:0]              func3  [RS_SIZE];
  logic                    func1  [RS_SIZE];
  logic [31:0]             v1     [RS_SIZE];
  logic [31:0]             v2     [RS_SIZE];
  logic [ROB_ID_WIDTH-1:0] q1     [RS_SIZE];
  logic [ROB_ID_WIDTH-1:0] q2     [RS_SIZE];
  logic [31:0]             imm    [RS_SIZE];
  logic [31:0]             off    [RS_SIZE];
  logic [31:0]             pc     [RS_SIZE];
  logic [ROB_ID_WIDTH-1:0] rob    [RS_SIZE];

  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             disp_found;
  logic [IDX_W-1:0] disp_idx;
  logic [31:0]      byp_v1;
  logic [31:0]      byp_v2;
  logic             byp_r1;
  logic             byp_r2;

  assign rs_full = &busy;

  // Downward scans so the last hit is the lowest index.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    disp_found = 1'b0;
    disp_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (busy[i] && r1[i] && r2[i]) begin
        disp_found = 1'b1;
        disp_idx   = IDX_W'(i);
      end
    end
  end

  // Operands produced by this cycle's broadcasts are captured on insert; ALU wins ties.
  always_comb begin
    byp_v1 = in_rs1_val;
    byp_r1 = in_rs1_rdy;
    byp_v2 = in_rs2_val;
    byp_r2 = in_rs2_rdy;
    if (!in_rs1_rdy) begin
      if (alu_valid && alu_rob == in_rs1_tag) begin
        byp_v1 = alu_data;
        byp_r1 = 1'b1;
      end else if (lsb_valid && lsb_rob == in_rs1_tag) begin
        byp_v1 = lsb_data;
        byp_r1 = 1'b1;
      end
    end
    if (!in_rs2_rdy) begin
      if (alu_valid && alu_rob == in_rs2_tag) begin
        byp_v2 = alu_data;
        byp_r2 = 1'b1;
      end else if (lsb_valid && lsb_rob == in_rs2_tag) begin
        byp_v2 = lsb_data;
        byp_r2 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (rdy && rollback)) begin
      busy           <= '0;
      out_inst_valid <= 1'b0;
      out_opcode     <= '0;
      out_func3      <= '0;
      out_func1      <= 1'b0;
      out_data1      <= '0;
      out_data2      <= '0;
      out_imm        <= '0;
      out_off        <= '0;
      out_pc         <= '0;
      out_rob_target <= '0;
    end else if (rdy) begin
      out_inst_valid <= disp_found;
      if (disp_found) begin
        busy[disp_idx] <= 1'b0;
        out_opcode     <= opcode[disp_idx];
        out_func3      <= func3[disp_idx];
        out_func1      <= func1[disp_idx];
        out_data1      <= v1[disp_idx];
        out_data2      <= v2[disp_idx];
        out_imm        <= imm[disp_idx];
        out_off        <= off[disp_idx];
        out_pc         <= pc[disp_idx];
        out_rob_target <= rob[disp_idx];
      end

      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i] && !r1[i]) begin
          if (alu_valid && alu_rob == q1[i]) begin
            v1[i] <= alu_data;
            r1[i] <= 1'b1;
          end else if (lsb_valid && lsb_rob == q1[i]) begin
            v1[i] <= lsb_data;
            r1[i] <= 1'b1;
          end
        end
        if (busy[i] && !r2[i]) begin
          if (alu_valid && alu_rob == q2[i]) begin
            v2[i] <= alu_data;
            r2[i] <= 1'b1;
          end else if (lsb_valid && lsb_rob == q2[i]) begin
            v2[i] <= lsb_data;
            r2[i] <= 1'b1;
          end
        end
      end

      // Insert only targets an entry that is idle in registered state, so it never collides with dispatch or wakeup.
      if (in_valid && free_found) begin
        busy[free_idx]   <= 1'b1;
        opcode[free_idx] <= in_opcode;
        func3[free_idx]  <= in_func3;
        func1[free_idx]  <= in_func1;
        v1[free_idx]     <= byp_v1;
        r1[free_idx]     <= byp_r1;
        q1[free_idx]     <= in_rs1_tag;
        v2[free_idx]     <= byp_v2;
        r2[free_idx]     <= byp_r2;
        q2[free_idx]     <= in_rs2_tag;
        imm[free_idx]    <= in_imm;
        off[free_idx]    <= in_off;
        pc[free_idx]     <= in_pc;
        rob[free_idx]    <= in_rob_target;
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station; a scoreboard queue holds the
// expected dispatch stream, drained by a monitor on the falling edge.
module tb_reservation_station;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic        func1;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [31:0] off;
    logic [31:0] pc;
    logic [3:0]  rob;
  } disp_t;

  logic        clk, rst, rdy, rollback, in_valid;
  logic [6:0]  in_opcode;
  logic [2:0]  in_func3;
  logic        in_func1;
  logic [31:0] in_rs1_val, in_rs2_val, in_imm, in_off, in_pc;
  logic        in_rs1_rdy, in_rs2_rdy;
  logic [3:0]  in_rs1_tag, in_rs2_tag, in_rob_target;
  logic        alu_valid, lsb_valid;
  logic [3:0]  alu_rob, lsb_rob;
  logic [31:0] alu_data, lsb_data;
  logic        rs_full, out_inst_valid;
  logic [6:0]  out_opcode;
  logic [2:0]  out_func3;
  logic        out_func1;
  logic [31:0] out_data1, out_data2, out_imm, out_off, out_pc;
  logic [3:0]  out_rob_target;

  int    compared = 0;
  int    mismatched = 0;
  disp_t sb[$];
  logic  live_edge = 1'b0;

  localparam logic [6:0] OP_ARITH  = 7'b0110011;
  localparam logic [6:0] OP_ARITHI = 7'b0010011;

  reservation_station #(.RS_SIZE(16), .ROB_ID_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .in_valid(in_valid),
    .in_opcode(in_opcode), .in_func3(in_func3), .in_func1(in_func1),
    .in_rs1_val(in_rs1_val), .in_rs1_rdy(in_rs1_rdy), .in_rs1_tag(in_rs1_tag),
    .in_rs2_val(in_rs2_val), .in_rs2_rdy(in_rs2_rdy), .in_rs2_tag(in_rs2_tag),
    .in_imm(in_imm), .in_off(in_off), .in_pc(in_pc), .in_rob_target(in_rob_target),
    .alu_valid(alu_valid), .alu_rob(alu_rob), .alu_data(alu_data),
    .lsb_valid(lsb_valid), .lsb_rob(lsb_rob), .lsb_data(lsb_data),
    .rs_full(rs_full), .out_inst_valid(out_inst_valid),
    .out_opcode(out_opcode), .out_func3(out_func3), .out_func1(out_func1),
    .out_data1(out_data1), .out_data2(out_data2), .out_imm(out_imm),
    .out_off(out_off), .out_pc(out_pc), .out_rob_target(out_rob_target)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one instruction for a single edge; broadcasts set by the caller stay as they are.
  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic f1,
                               input logic [31:0] v1, input logic r1, input logic [3:0] t1,
                               input logic [31:0] v2, input logic r2, input logic [3:0] t2,
                               input logic [31:0] imm, input logic [31:0] off,
                               input logic [31:0] pc, input logic [3:0] rob);
    in_valid   = 1'b1;
    in_opcode  = op;   in_func3   = f3;  in_func1 = f1;
    in_rs1_val = v1;   in_rs1_rdy = r1;  in_rs1_tag = t1;
    in_rs2_val = v2;   in_rs2_rdy = r2;  in_rs2_tag = t2;
    in_imm     = imm;  in_off     = off; in_pc = pc; in_rob_target = rob;
    tick();
    in_valid   = 1'b0;
  endtask

  task automatic broadcastAlu(input logic [3:0] tag, input logic [31:0] data);
    alu_valid = 1'b1; alu_rob = tag; alu_data = data;
    tick();
    alu_valid = 1'b0;
  endtask

  function automatic disp_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f1,
                               input logic [31:0] d1, input logic [31:0] d2,
                               input logic [31:0] imm, input logic [31:0] off,
                               input logic [31:0] pc, input logic [3:0] rob);
    disp_t e;
    e.opcode = op; e.func3 = f3; e.func1 = f1; e.d1 = d1; e.d2 = d2;
    e.imm = imm; e.off = off; e.pc = pc; e.rob = rob;
    return e;
  endfunction

  // Only edges where the RS was enabled and out of reset can produce a new issue pulse.
  always @(posedge clk) begin
    live_edge <= rdy && !rst;
    if (!rst && rdy && !rollback && in_valid)
      checkOutput("insert_while_full", 256'(rs_full), 256'(0));
  end

  always @(negedge clk) begin
    if (live_edge && out_inst_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_dispatch", 256'(out_inst_valid), 256'(0));
      end else begin
        disp_t e;
        disp_t o;
        e = sb.pop_front();
        o = mk(out_opcode, out_func3, out_func1, out_data1, out_data2,
               out_imm, out_off, out_pc, out_rob_target);
        checkOutput("dispatch", 256'(o), 256'(e));
      end
    end
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; in_valid = 1'b0;
    in_opcode = '0; in_func3 = '0; in_func1 = 1'b0;
    in_rs1_val = '0; in_rs1_rdy = 1'b0; in_rs1_tag = '0;
    in_rs2_val = '0; in_rs2_rdy = 1'b0; in_rs2_tag = '0;
    in_imm = '0; in_off = '0; in_pc = '0; in_rob_target = '0;
    alu_valid = 1'b0; alu_rob = '0; alu_data = '0;
    lsb_valid = 1'b0; lsb_rob = '0; lsb_data = '0;
    tick(); tick();
    rst = 1'b0;
    checkOutput("reset_valid", 256'(out_inst_valid), 256'(0));
    checkOutput("reset_full", 256'(rs_full), 256'(0));
    checkOutput("reset_data1", 256'(out_data1), 256'(0));
    checkOutput("reset_rob", 256'(out_rob_target), 256'(0));

    // Ready ADD issues one edge after insertion, pulse lasts one cycle.
    sb.push_back(mk(OP_ARITH, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0, 32'h100, 4'd3));
    applyStimulus(OP_ARITH, 3'd0, 1'b0, 32'd5, 1'b1, 4'd0, 32'd7, 1'b1, 4'd0, 32'd0, 32'd0, 32'h100, 4'd3);
    checkOutput("t1_valid_insert_edge", 256'(out_inst_valid), 256'(0));
    tick();
    checkOutput("t1_valid_pulse", 256'(out_inst_valid), 256'(1));
    tick();
    checkOutput("t1_valid_drop", 256'(out_inst_valid), 256'(0));
    checkOutput("t1_data1_hold", 256'(out_data1), 256'(5));

    // SUB waiting on tag 2, woken by an ALU broadcast.
    sb.push_back(mk(OP_ARITH, 3'd0, 1'b1, 32'h10, 32'd3, 32'd0, 32'd0, 32'h104, 4'd4));
    applyStimulus(OP_ARITH, 3'd0, 1'b1, 32'd0, 1'b0, 4'd2, 32'd3, 1'b1, 4'd0, 32'd0, 32'd0, 32'h104, 4'd4);
    broadcastAlu(4'd2, 32'h10);
    checkOutput("t2_wake_edge", 256'(out_inst_valid), 256'(0));
    tick();
    checkOutput("t2_dispatch", 256'(out_inst_valid), 256'(1));
    tick();

    // Same-cycle LSB bypass on rs2.
    lsb_valid = 1'b1; lsb_rob = 4'd5; lsb_data = 32'hAB;
    sb.push_back(mk(OP_ARITHI, 3'd7, 1'b0, 32'd1, 32'hAB, 32'h2A, 32'd0, 32'h108, 4'd6));
    applyStimulus(OP_ARITHI, 3'd7, 1'b0, 32'd1, 1'b1, 4'd0, 32'd0, 1'b0, 4'd5, 32'h2A, 32'd0, 32'h108, 4'd6);
    lsb_valid = 1'b0;
    tick();
    checkOutput("t3_dispatch", 256'(out_inst_valid), 256'(1));
    tick();

    // Fill all sixteen entries waiting on tag 9, then drain in index order.
    for (int i = 0; i < 16; i++) begin
      sb.push_back(mk(OP_ARITH, 3'd1, 1'b0, 32'h99, 32'(i), 32'd0, 32'(i), 32'h200 + 32'(4 * i), 4'(i)));
      applyStimulus(OP_ARITH, 3'd1, 1'b0, 32'd0, 1'b0, 4'd9, 32'(i), 1'b1, 4'd0, 32'd0, 32'(i), 32'h200 + 32'(4 * i), 4'(i));
    end
    checkOutput("t4_full", 256'(rs_full), 256'(1));
    checkOutput("t4_no_issue_while_waiting", 256'(out_inst_valid), 256'(0));
    broadcastAlu(4'd9, 32'h99);
    checkOutput("t4_full_after_wake", 256'(rs_full), 256'(1));
    tick();
    checkOutput("t4_first_dispatch", 256'(out_inst_valid), 256'(1));
    checkOutput("t4_full_drop", 256'(rs_full), 256'(0));
    for (int i = 0; i < 16; i++) tick();
    checkOutput("t4_drained", 256'(sb.size()), 256'(0));

    // Rollback discards pending entries; a later broadcast must not revive them.
    for (int i = 0; i < 4; i++)
      applyStimulus(OP_ARITH, 3'd0, 1'b0, 32'd0, 1'b0, 4'd11, 32'd1, 1'b1, 4'd0, 32'd0, 32'd0, 32'h300, 4'(i));
    rollback = 1'b1;
    alu_valid = 1'b1; alu_rob = 4'd11; alu_data = 32'hDEAD;
    tick();
    rollback = 1'b0;
    alu_valid = 1'b0;
    checkOutput("t5_full", 256'(rs_full), 256'(0));
    checkOutput("t5_valid", 256'(out_inst_valid), 256'(0));
    broadcastAlu(4'd11, 32'h1234);
    tick(); tick();
    checkOutput("t5_no_dispatch", 256'(out_inst_valid), 256'(0));

    // Stall: neither dispatch nor wakeup may happen while rdy is low.
    applyStimulus(OP_ARITH, 3'd4, 1'b0, 32'd0, 1'b0, 4'd12, 32'd2, 1'b1, 4'd0, 32'd0, 32'd0, 32'h400, 4'd8);
    sb.push_back(mk(OP_ARITH, 3'd6, 1'b0, 32'h21, 32'h22, 32'd0, 32'd0, 32'h404, 4'd7));
    applyStimulus(OP_ARITH, 3'd6, 1'b0, 32'h21, 1'b1, 4'd0, 32'h22, 1'b1, 4'd0, 32'd0, 32'd0, 32'h404, 4'd7);
    rdy = 1'b0;
    alu_valid = 1'b1; alu_rob = 4'd12; alu_data = 32'h55;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t6_stall_valid", 256'(out_inst_valid), 256'(0));
    end
    alu_valid = 1'b0;
    rdy = 1'b1;
    tick();
    checkOutput("t6_resume_dispatch", 256'(out_inst_valid), 256'(1));
    tick();
    checkOutput("t6_no_stale_wakeup", 256'(out_inst_valid), 256'(0));
    sb.push_back(mk(OP_ARITH, 3'd4, 1'b0, 32'h66, 32'd2, 32'd0, 32'd0, 32'h400, 4'd8));
    broadcastAlu(4'd12, 32'h66);
    tick();
    checkOutput("t6_late_dispatch", 256'(out_inst_valid), 256'(1));
    tick();

    // Insert into the last free entry while another entry dispatches.
    for (int i = 0; i < 14; i++)
      applyStimulus(OP_ARITH, 3'd2, 1'b0, 32'd0, 1'b0, 4'd13, 32'(i), 1'b1, 4'd0, 32'd0, 32'd0, 32'h500 + 32'(i), 4'(i));
    sb.push_back(mk(OP_ARITH, 3'd3, 1'b0, 32'hA, 32'hB, 32'd0, 32'd0, 32'h600, 4'd14));
    applyStimulus(OP_ARITH, 3'd3, 1'b0, 32'hA, 1'b1, 4'd0, 32'hB, 1'b1, 4'd0, 32'd0, 32'd0, 32'h600, 4'd14);
    checkOutput("t7_not_full", 256'(rs_full), 256'(0));
    sb.push_back(mk(OP_ARITH, 3'd5, 1'b1, 32'hC, 32'hD, 32'd0, 32'd0, 32'h604, 4'd15));
    applyStimulus(OP_ARITH, 3'd5, 1'b1, 32'hC, 1'b1, 4'd0, 32'hD, 1'b1, 4'd0, 32'd0, 32'd0, 32'h604, 4'd15);
    checkOutput("t7_overlap_dispatch", 256'(out_inst_valid), 256'(1));
    checkOutput("t7_full_after_overlap", 256'(rs_full), 256'(0));
    tick();
    checkOutput("t7_second_dispatch", 256'(out_inst_valid), 256'(1));
    for (int i = 0; i < 14; i++)
      sb.push_back(mk(OP_ARITH, 3'd2, 1'b0, 32'h77, 32'(i), 32'd0, 32'd0, 32'h500 + 32'(i), 4'(i)));
    broadcastAlu(4'd13, 32'h77);
    for (int i = 0; i < 16; i++) tick();
    checkOutput("t7_drained", 256'(sb.size()), 256'(0));
    checkOutput("t7_empty_full", 256'(rs_full), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
